// File: rtl/lfsr_pkg.sv
// lfsr_gen shared types: FSM encoding and feedback mode constants.
// Imported by lfsr_next and lfsr_gen.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam int LFSR_FIB = 0;
  localparam int LFSR_GAL = 1;

endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen control/status bundle.
// master drives step/load controls, slave returns LFSR status.
interface lfsr_gen_if #(
  parameter int WIDTH = 4
);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_flag;
  logic [WIDTH-1:0] step_count;
  logic             period_done;
  logic             lockup;

  modport master (
    output enable,
    output load,
    output seed_in,
    input  data_out,
    input  valid_flag,
    input  step_count,
    input  period_done,
    input  lockup
  );

  modport slave (
    input  enable,
    input  load,
    input  seed_in,
    output data_out,
    output valid_flag,
    output step_count,
    output period_done,
    output lockup
  );

endinterface

// File: rtl/lfsr_next.sv
// Combinational LFSR successor function.
// Fibonacci shifts in the tap parity; Galois xors TAPS on msb out.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter int               MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  generate
    if (MODE == LFSR_GAL) begin : g_gal
      assign next = {state[WIDTH-2:0], 1'b0}
                  ^ (state[WIDTH-1] ? TAPS : '0);
    end else begin : g_fib
      assign next = {state[WIDTH-2:0], ^(state & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR pattern source with load, step count and lockup.
// Macro LFSR_LOCKUP_RECOVER_EN: auto-reload SEED after one LOCKED cycle.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001,
  parameter int               MODE  = LFSR_FIB
) (
  input logic        clock,
  input logic        reset,
  lfsr_gen_if.slave  bus
);

  lfsr_state_e      st_q, st_n;
  logic [WIDTH-1:0] state_q, state_n;
  logic [WIDTH-1:0] ref_q, ref_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  logic             valid_q, valid_n;
  logic             pd_q, pd_n;
  logic             lock_q, lock_n;
  logic [WIDTH-1:0] nxt;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_next (
    .state (state_q),
    .next  (nxt)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_n;
  end

  // next-state and datapath update; load beats enable
  always_comb begin
    st_n    = st_q;
    state_n = state_q;
    ref_n   = ref_q;
    cnt_n   = cnt_q;
    valid_n = 1'b0;
    pd_n    = 1'b0;
    unique case (st_q)
      IDLE, RUN: begin
        if (bus.load) begin
          state_n = bus.seed_in;
          ref_n   = bus.seed_in;
          cnt_n   = '0;
          st_n    = (bus.seed_in == '0) ? LOCKED : IDLE;
        end else if (bus.enable) begin
          state_n = nxt;
          cnt_n   = cnt_q + 1'b1;
          valid_n = 1'b1;
          pd_n    = (nxt == ref_q);
          st_n    = (nxt == '0) ? LOCKED : RUN;
        end
      end
      LOCKED: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
        state_n = SEED;
        ref_n   = SEED;
        cnt_n   = '0;
        st_n    = IDLE;
`else
        if (bus.load) begin
          state_n = bus.seed_in;
          ref_n   = bus.seed_in;
          cnt_n   = '0;
          st_n    = (bus.seed_in == '0) ? LOCKED : IDLE;
        end
`endif
      end
      default: st_n = IDLE;
    endcase
    lock_n = (st_n == LOCKED);
  end

  // registered datapath and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pd_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ref_q   <= ref_n;
      cnt_q   <= cnt_n;
      valid_q <= valid_n;
      pd_q    <= pd_n;
      lock_q  <= lock_n;
    end
  end

  assign bus.data_out    = state_q;
  assign bus.valid_flag  = valid_q;
  assign bus.step_count  = cnt_q;
  assign bus.period_done = pd_q;
  assign bus.lockup      = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (Fibonacci and Galois instances).
// Table of vectors feeds a scoreboard queue; corner cases by hand.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  typedef struct {
    logic       en;
    logic       ld;
    logic [3:0] seed;
    logic [3:0] d;
    logic       v;
    logic [3:0] c;
    logic       pd;
    logic       lk;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lfsr_gen_if #(.WIDTH(4)) fi();
  lfsr_gen_if #(.WIDTH(4)) gi();

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .MODE(LFSR_FIB)
  ) dut_f (
    .clock(clock), .reset(reset), .bus(fi.slave)
  );

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .MODE(LFSR_GAL)
  ) dut_g (
    .clock(clock), .reset(reset), .bus(gi.slave)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  vec_t sb[$];
  logic [3:0] fs[15];
  logic [3:0] gs[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic ld,
      input logic [3:0] seed, input logic [3:0] d, input logic v,
      input logic [3:0] c, input logic pd, input logic lk);
    vec_t r;
    r.en = en; r.ld = ld; r.seed = seed; r.d = d;
    r.v = v; r.c = c; r.pd = pd; r.lk = lk;
    return r;
  endfunction

  task automatic drive(input vec_t v, input string tag);
    vec_t e;
    @(negedge clock);
    fi.enable = v.en; fi.load = v.ld; fi.seed_in = v.seed;
    gi.enable = v.en; gi.load = v.ld; gi.seed_in = v.seed;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({tag, "_data"}, 32'(fi.data_out), 32'(e.d));
    chk({tag, "_valid"}, 32'(fi.valid_flag), 32'(e.v));
    chk({tag, "_count"}, 32'(fi.step_count), 32'(e.c));
    chk({tag, "_pd"}, 32'(fi.period_done), 32'(e.pd));
    chk({tag, "_lock"}, 32'(fi.lockup), 32'(e.lk));
  endtask

  initial begin
    fs = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
           4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
           4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    gs = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011,
           4'b1111, 4'b0111, 4'b1110, 4'b0101, 4'b1010,
           4'b1101, 4'b0011, 4'b0110, 4'b1100, 4'b0001};

    // full Fibonacci period from reset
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(1, 0, 0, fs[k-1], 1, 4'(k), k == 15, 0));
    // load and enable together: load wins
    tbl.push_back(mk(1, 1, 4'b1010, 4'b1010, 0, 0, 0, 0));
    // period relative to the loaded reference 1010 (fs index 5)
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(1, 0, 0, fs[(5 + k) % 15], 1, 4'(k), k == 15, 0));
    // enable gaps 1,0,0,1; first step wraps the count to 0
    tbl.push_back(mk(1, 0, 0, 4'b0101, 1, 4'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0101, 0, 4'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0101, 0, 4'd0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'b1011, 1, 4'd1, 0, 0));

    fi.enable = 0; fi.load = 0; fi.seed_in = 0;
    gi.enable = 0; gi.load = 0; gi.seed_in = 0;

    #12;
    chk("rst_hold_data", 32'(fi.data_out), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_data", 32'(fi.data_out), 32'h1);
    chk("rst_count", 32'(fi.step_count), 32'h0);
    chk("rst_valid", 32'(fi.valid_flag), 32'h0);
    chk("rst_pd", 32'(fi.period_done), 32'h0);
    chk("rst_lock", 32'(fi.lockup), 32'h0);
    chk("rst_gal_data", 32'(gi.data_out), 32'h1);

    foreach (tbl[i]) begin
      drive(tbl[i], $sformatf("v%0d", i));
      if (i < 15) begin
        chk($sformatf("gal%0d_data", i), 32'(gi.data_out), 32'(gs[i]));
        chk($sformatf("gal%0d_pd", i), 32'(gi.period_done),
            32'(i == 14));
      end
    end

    // zero seed lockup
    drive(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1), "zload");
`ifdef LFSR_LOCKUP_RECOVER_EN
    drive(mk(1, 0, 0, 4'b0001, 0, 0, 0, 0), "zrecov");
    drive(mk(1, 0, 0, 4'b0011, 1, 1, 0, 0), "zstep");
`else
    drive(mk(1, 0, 0, 4'b0000, 0, 0, 0, 1), "zhold1");
    drive(mk(1, 0, 0, 4'b0000, 0, 0, 0, 1), "zhold2");
`endif
    drive(mk(0, 1, 4'b0011, 4'b0011, 0, 0, 0, 0), "zfix");
    drive(mk(1, 0, 0, 4'b0111, 1, 1, 0, 0), "zrun");

    // asynchronous reset after 7 steps
    drive(mk(0, 1, 4'b0001, 4'b0001, 0, 0, 0, 0), "aload");
    for (int k = 1; k <= 7; k++)
      drive(mk(1, 0, 0, fs[k-1], 1, 4'(k), 0, 0),
            $sformatf("astep%0d", k));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", 32'(fi.data_out), 32'h1);
    chk("arst_count", 32'(fi.step_count), 32'h0);
    chk("arst_valid", 32'(fi.valid_flag), 32'h0);
    chk("arst_gal_data", 32'(gi.data_out), 32'h1);
    @(negedge clock);
    fi.enable = 0; gi.enable = 0;
    reset = 1'b0;
    drive(mk(1, 0, 0, 4'b0011, 1, 1, 0, 0), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the fixed 4-bit LFSR. Configurable width, tap mask, seed and Fibonacci/Galois mode.
- Adds step enable, runtime seed load, a per-step valid strobe, a step counter, period-completion detection and all-zero lockup detection.
- Used as a pattern/PRBS source for the team's test and scrambler blocks.

Parameters:
- WIDTH, 4: LFSR register width (2..32).
- TAPS, 4'b1001: feedback mask; bit i set means state bit i participates in feedback.
- SEED, 4'b0001: reset value of the state and of the reference seed; must be non-zero.
- MODE, 0: 0 = Fibonacci, 1 = Galois.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance the LFSR one step this cycle.
- load  in  1  load seed_in into the state; takes priority over enable.
- seed_in  in  WIDTH  seed value captured on load.
- data_out  out  WIDTH  current LFSR state.
- valid_flag  out  1  high for the one cycle after data_out was advanced.
- step_count  out  WIDTH  number of steps since the last load or reset; wraps modulo 2^WIDTH.
- period_done  out  1  one-cycle pulse when a step returns the state to the reference seed.
- lockup  out  1  state is all-zero.

Behaviour:
- Clock and reset:
  - One clock: `clock`, rising edge.
  - Reset is asynchronous and active-high on port `reset`.
- Reset values:
  - data_out = SEED; internal ref_seed = SEED.
  - step_count = 0; valid_flag = 0; period_done = 0; lockup = 0.
  - FSM in IDLE.
- Next-state rules, evaluated on each accepted step:
  - Fibonacci (MODE=0): fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
  - Galois (MODE=1): next = {state[WIDTH-2:0], 1'b0} XOR (state[WIDTH-1] ? TAPS : 0).
- FSM states and transitions:
  - IDLE: enable=1 → step, go RUN. load=1 → load, stay IDLE.
  - RUN: enable=1 → step. enable=0 → hold state, valid_flag=0. load=1 → load, go IDLE.
  - LOCKED: entered whenever the state is all-zero. Steps are ignored; lockup=1. load with a non-zero seed → IDLE.
- Load:
  - state ← seed_in; ref_seed ← seed_in; step_count ← 0.
  - valid_flag = 0 and period_done = 0 on the following cycle.
  - load together with enable: load wins and no step occurs.
  - load with seed_in = 0 → LOCKED.
- Step (1-cycle latency):
  - state ← next; step_count ← step_count + 1 (wraps).
  - valid_flag = 1 next cycle.
  - period_done = 1 next cycle iff next == ref_seed. step_count is NOT cleared on period_done.
- Hold: with enable=0, data_out and step_count are stable.
- Reset mid-operation: all outputs return to reset values immediately, independent of clock.
- Outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - LOCKED lasts exactly one cycle (lockup=1 for that cycle).
  - State then auto-reloads SEED, ref_seed ← SEED, step_count ← 0, FSM → IDLE.
- Undefined:
  - LOCKED persists until reset or a load with a non-zero seed.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, LOCKED = 2'd2.
  - MODE constants: LFSR_FIB = 0, LFSR_GAL = 1.
- Sub-module lfsr_next (combinational): computes the next state from state, TAPS and MODE.
- lfsr_gen holds the FSM, counters and flags.

Test Plan:
- Fibonacci period: WIDTH=4, TAPS=4'b1001, MODE=0; release reset, hold enable=1.
  - data_out sequence: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001.
  - period_done pulses on the 15th step; step_count = 15.
- Galois period: MODE=1, same TAPS.
  - data_out sequence: 0001, 0010, 0100, 1000, 1001, 1011, 1111, 0111, 1110, 0101, 1010, 1101, 0011, 0110, 1100, 0001.
  - period_done on the 15th step.
- Load vs enable: load=1, enable=1, seed_in=4'b1010 in the same cycle.
  - data_out=1010, step_count=0, valid_flag=0.
  - The next enable gives 0101 (Fibonacci); period_done fires when the state returns to 1010.
- Enable gaps: toggle enable 1,0,0,1.
  - data_out and step_count hold during the gaps.
  - valid_flag pattern is 1,0,0,1, delayed by one cycle.
- Zero seed: load seed_in=0, then enable.
  - Without the macro: lockup=1, data_out stays 0000 until a load of 0011, which gives lockup=0.
  - With LFSR_LOCKUP_RECOVER_EN: lockup=1 for one cycle, then data_out=0001.
- Asynchronous reset mid-run: after 7 steps, assert reset between clock edges.
  - Outputs return to data_out=0001 and step_count=0 before the next edge.
